// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RV32I funct3 codes,
// byte-enable patterns and the request legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsuState_e;

    localparam logic [2:0] FN3_LB  = 3'b000;
    localparam logic [2:0] FN3_LH  = 3'b001;
    localparam logic [2:0] FN3_LW  = 3'b010;
    localparam logic [2:0] FN3_LBU = 3'b100;
    localparam logic [2:0] FN3_LHU = 3'b101;
    localparam logic [2:0] FN3_SB  = 3'b000;
    localparam logic [2:0] FN3_SH  = 3'b001;
    localparam logic [2:0] FN3_SW  = 3'b010;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // High when the funct3 is not a legal access of that direction or the address is misaligned.
    function automatic logic lsuFault(input logic we, input logic [2:0] fn3, input logic [1:0] lane);
        logic bad;
        bad = 1'b1;
        if (we) begin
            case (fn3)
                FN3_SB:  bad = 1'b0;
                FN3_SH:  bad = lane[0];
                FN3_SW:  bad = |lane;
                default: bad = 1'b1;
            endcase
        end else begin
            case (fn3)
                FN3_LB, FN3_LBU: bad = 1'b0;
                FN3_LH, FN3_LHU: bad = lane[0];
                FN3_LW:          bad = |lane;
                default:         bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit: store byte enables and lane
// replication, load lane extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  fn3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [15:0] laneData;

    assign laneData = 16'(rdata_i >> {lane_i, 3'b000});

    always_comb begin
        be_o    = BE_WORD;
        wdata_o = wdata_i;
        if (we_i) begin
            case (fn3_i)
                FN3_SB: begin
                    be_o    = BE_BYTE << lane_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                FN3_SH: begin
                    be_o    = BE_HALF << lane_i;
                    wdata_o = {2{wdata_i[15:0]}};
                end
                default: be_o = BE_WORD;
            endcase
        end
    end

    always_comb begin
        case (fn3_i)
            FN3_LB:  rdata_o = {{24{laneData[7]}}, laneData[7:0]};
            FN3_LH:  rdata_o = {{16{laneData[15]}}, laneData};
            FN3_LBU: rdata_o = {24'd0, laneData[7:0]};
            FN3_LHU: rdata_o = {16'd0, laneData};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit bridging one core request port onto NUM_SLAVES memory-mapped slaves.
// Define LSU_TIMEOUT_EN to abort accesses whose slave never acknowledges.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int                         NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*32-1:0]   SLV_BASE       = {32'h2000_0000, 32'h1000_2000,
                                                            32'h1000_0000, 32'h8000_0000},
    parameter logic [NUM_SLAVES*32-1:0]   SLV_MASK       = {32'hFFFF_0000, 32'hFFFF_FFF0,
                                                            32'hFFFF_FFF0, 32'hFFFF_0000},
    parameter int                         TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    input  logic [2:0]               req_fn3,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err,
    output logic [NUM_SLAVES-1:0]    s_sel,
    output logic                     s_we,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_be,
    input  logic [NUM_SLAVES*32-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]    s_ack
);

    lsuState_e             state_q, state_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic [29:0]           offset_q, offset_d;
    logic [1:0]            lane_q, lane_d;
    logic                  we_q, we_d;
    logic [2:0]            fn3_q, fn3_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

`ifdef LSU_TIMEOUT_EN
    localparam int TimerW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TimerW-1:0]     timer_q, timer_d;
`endif

    logic [NUM_SLAVES-1:0] hitSel;
    logic [29:0]           hitOffset;
    logic [31:0]           selRdata;
    logic                  slaveAck;
    logic [3:0]            alignBe;
    logic [31:0]           alignWdata;
    logic [31:0]           alignRdata;

    // Walk from the highest index down so the lowest matching slave overwrites the rest.
    always_comb begin
        hitSel    = '0;
        hitOffset = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((req_addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
                hitSel    = '0;
                hitSel[i] = 1'b1;
                hitOffset = req_addr[31:2] & ~SLV_MASK[i*32+2 +: 30];
            end
        end
    end

    always_comb begin
        selRdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                selRdata = selRdata | s_rdata[i*32 +: 32];
            end
        end
    end

    assign slaveAck = |(s_ack & sel_q);

    lsu_align uAlign (
        .we_i    (we_q),
        .fn3_i   (fn3_q),
        .lane_i  (lane_q),
        .wdata_i (wdata_q),
        .rdata_i (selRdata),
        .be_o    (alignBe),
        .wdata_o (alignWdata),
        .rdata_o (alignRdata)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        offset_d = offset_q;
        lane_d   = lane_q;
        we_d     = we_q;
        fn3_d    = fn3_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef LSU_TIMEOUT_EN
        timer_d  = timer_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    offset_d = hitOffset;
                    lane_d   = req_addr[1:0];
                    we_d     = req_we;
                    fn3_d    = req_fn3;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
`ifdef LSU_TIMEOUT_EN
                    timer_d  = '0;
`endif
                    if (hitSel == '0 || lsuFault(req_we, req_fn3, req_addr[1:0])) begin
                        sel_d   = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        sel_d   = hitSel;
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (slaveAck) begin
                    rdata_d = we_q ? '0 : alignRdata;
                    state_d = RESP;
                end
`ifdef LSU_TIMEOUT_EN
                else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            offset_q <= '0;
            lane_q   <= '0;
            we_q     <= 1'b0;
            fn3_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            timer_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            offset_q <= offset_d;
            lane_q   <= lane_d;
            we_q     <= we_d;
            fn3_q    <= fn3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef LSU_TIMEOUT_EN
            timer_q  <= timer_d;
`endif
        end
    end

    // Bus strobes are gated by state so a reset drops them without waiting for a clock.
    assign req_ready = (state_q == IDLE);
    assign s_sel     = (state_q == ACCESS) ? sel_q : '0;
    assign s_we      = (state_q == ACCESS) & we_q;
    assign s_be      = (state_q == ACCESS) ? alignBe : BE_NONE;
    assign s_addr    = {offset_q, 2'b00};
    assign s_wdata   = alignWdata;
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, randomized requests
// against a reference model, and reset/timeout sequences (timeout only with LSU_TIMEOUT_EN).
module tb_load_store_unit;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic [2:0]   req_fn3;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic [3:0]   s_sel;
    logic         s_we;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_be;
    logic [127:0] s_rdata;
    logic [3:0]   s_ack;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] BASES [4] = '{32'h8000_0000, 32'h1000_0000, 32'h1000_2000, 32'h2000_0000};
    localparam logic [31:0] MASKS [4] = '{32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_0000};

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rd;
        logic [3:0]  sel;
        logic [3:0]  be;
        logic [31:0] saddr;
        logic [31:0] swdata;
        logic        swe;
        logic        readyBusy;
    } obs_t;

    typedef struct {
        logic        we;
        logic [2:0]  fn3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] srd;
        int          ackWait;
        logic [3:0]  eSel;
        logic [3:0]  eBe;
        logic [31:0] eSAddr;
        logic [31:0] eSWdata;
        logic [31:0] eRdata;
        logic        eErr;
        int          eLat;
    } vec_t;

    vec_t vecs [14];

    load_store_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_fn3   (req_fn3),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .s_sel     (s_sel),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_be      (s_be),
        .s_rdata   (s_rdata),
        .s_ack     (s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
        end
    endtask

    // Issue one request, play the slave side, and record what appears on the bus and response.
    task automatic applyStimulus(input logic we, input logic [2:0] fn3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] srd,
                                 input int ackWait, input int maxCycles, output obs_t o);
        int waits;
        o.lat = 0; o.err = 1'b0; o.rd = '0; o.sel = '0; o.be = '0;
        o.saddr = '0; o.swdata = '0; o.swe = 1'b0; o.readyBusy = 1'b1;
        waits = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_fn3   = fn3;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_fn3   = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        for (int c = 1; c <= maxCycles && o.lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) o.readyBusy = req_ready;
            if (rsp_valid) begin
                o.lat = c;
                o.err = rsp_err;
                o.rd  = rsp_rdata;
            end
            if (s_sel != '0) begin
                o.sel    = o.sel | s_sel;
                o.be     = s_be;
                o.saddr  = s_addr;
                o.swdata = s_wdata;
                o.swe    = s_we;
            end
            for (int i = 0; i < 4; i++) s_rdata[i*32 +: 32] = s_sel[i] ? srd : $urandom;
            s_ack = 4'($urandom) & ~s_sel;
            if (s_sel != '0) begin
                if (waits == ackWait) s_ack = s_ack | s_sel;
                waits++;
            end
        end
        s_ack = '0;
    endtask

    task automatic checkTxn(input string tag, input logic we, input int eLat, input logic eErr,
                            input logic [31:0] eRdata, input logic [3:0] eSel, input logic [3:0] eBe,
                            input logic [31:0] eSAddr, input logic [31:0] eSWdata, input obs_t o);
        checkOutput($sformatf("%s latency", tag), 32'(o.lat), 32'(eLat));
        checkOutput($sformatf("%s rsp_err", tag), 32'(o.err), 32'(eErr));
        checkOutput($sformatf("%s rsp_rdata", tag), o.rd, eRdata);
        checkOutput($sformatf("%s s_sel", tag), 32'(o.sel), 32'(eSel));
        checkOutput($sformatf("%s req_ready busy", tag), 32'(o.readyBusy), 32'd0);
        if (eSel != '0) begin
            checkOutput($sformatf("%s s_be", tag), 32'(o.be), 32'(eBe));
            checkOutput($sformatf("%s s_addr", tag), o.saddr, eSAddr);
            checkOutput($sformatf("%s s_we", tag), 32'(o.swe), 32'(we));
            if (we) checkOutput($sformatf("%s s_wdata", tag), o.swdata, eSWdata);
        end
    endtask

    // Reference model: decode, legality, lanes and extension computed arithmetically.
    function automatic void refModel(input logic we, input logic [2:0] fn3, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [31:0] srd,
                                     output logic [3:0] eSel, output logic [3:0] eBe,
                                     output logic [31:0] eSAddr, output logic [31:0] eSWdata,
                                     output logic [31:0] eRdata, output logic eErr);
        int     slave;
        int     size;
        int     bits;
        bit     legal;
        longint v;
        slave = -1;
        for (int i = 0; i < 4; i++)
            if (slave < 0 && (addr & MASKS[i]) == BASES[i]) slave = i;
        if (we) legal = fn3 inside {3'b000, 3'b001, 3'b010};
        else    legal = fn3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        size = 1 << fn3[1:0];
        eErr = !legal || slave < 0 || (addr % size) != 0;
        eSel = '0; eSAddr = '0; eSWdata = '0; eRdata = '0;
        eBe  = we ? 4'(((1 << size) - 1) << (addr % 4)) : 4'hF;
        if (!eErr) begin
            eSel   = 4'(1 << slave);
            eSAddr = (addr & ~MASKS[slave]) & ~32'h3;
            for (int k = 0; k < 4; k++) eSWdata[k*8 +: 8] = wdata[(k % size)*8 +: 8];
            if (!we) begin
                bits = size * 8;
                v = longint'(srd) >> (8 * (addr % 4));
                v = v % (longint'(1) << bits);
                if (!fn3[2] && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
                eRdata = 32'(v);
            end
        end
    endfunction

    initial begin
        obs_t        o;
        logic        rWe;
        logic [2:0]  rFn3;
        logic [31:0] rAddr, rWdata, rSrd, eSAddr, eSWdata, eRdata;
        logic [3:0]  eSel, eBe;
        logic        eErr;
        int          rWait, k;

        vecs[0]  = '{1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0,         0, 4'b0001, 4'b1111, 32'h10,  32'hDEAD_BEEF, 32'h0,         1'b0, 2};
        vecs[1]  = '{1'b0, 3'b000, 32'h8000_0013, 32'h0,         32'h80FF_7F01, 0, 4'b0001, 4'b1111, 32'h10,  32'h0,         32'hFFFF_FF80, 1'b0, 2};
        vecs[2]  = '{1'b0, 3'b100, 32'h8000_0013, 32'h0,         32'h80FF_7F01, 0, 4'b0001, 4'b1111, 32'h10,  32'h0,         32'h0000_0080, 1'b0, 2};
        vecs[3]  = '{1'b0, 3'b001, 32'h8000_0001, 32'h0,         32'h0,         0, 4'b0000, 4'b0000, 32'h0,   32'h0,         32'h0,         1'b1, 1};
        vecs[4]  = '{1'b1, 3'b000, 32'h1000_0008, 32'h0000_0041, 32'h0,         0, 4'b0010, 4'b0001, 32'h8,   32'h4141_4141, 32'h0,         1'b0, 2};
        vecs[5]  = '{1'b0, 3'b010, 32'h4000_0000, 32'h0,         32'h0,         0, 4'b0000, 4'b0000, 32'h0,   32'h0,         32'h0,         1'b1, 1};
        vecs[6]  = '{1'b1, 3'b001, 32'h1000_2006, 32'h1234_ABCD, 32'h0,         3, 4'b0100, 4'b1100, 32'h4,   32'hABCD_ABCD, 32'h0,         1'b0, 5};
        vecs[7]  = '{1'b0, 3'b101, 32'h2000_0102, 32'h0,         32'hCAFE_1234, 1, 4'b1000, 4'b1111, 32'h100, 32'h0,         32'h0000_CAFE, 1'b0, 3};
        vecs[8]  = '{1'b0, 3'b001, 32'h2000_0102, 32'h0,         32'hCAFE_1234, 1, 4'b1000, 4'b1111, 32'h100, 32'h0,         32'hFFFF_CAFE, 1'b0, 3};
        vecs[9]  = '{1'b0, 3'b011, 32'h8000_0000, 32'h0,         32'h0,         0, 4'b0000, 4'b0000, 32'h0,   32'h0,         32'h0,         1'b1, 1};
        vecs[10] = '{1'b1, 3'b100, 32'h8000_0000, 32'h55,        32'h0,         0, 4'b0000, 4'b0000, 32'h0,   32'h0,         32'h0,         1'b1, 1};
        vecs[11] = '{1'b0, 3'b010, 32'h1000_000C, 32'h0,         32'h1122_3344, 2, 4'b0010, 4'b1111, 32'hC,   32'h0,         32'h1122_3344, 1'b0, 4};
        vecs[12] = '{1'b0, 3'b010, 32'h1000_0010, 32'h0,         32'h0,         0, 4'b0000, 4'b0000, 32'h0,   32'h0,         32'h0,         1'b1, 1};
        vecs[13] = '{1'b1, 3'b010, 32'h8000_0002, 32'h1,         32'h0,         0, 4'b0000, 4'b0000, 32'h0,   32'h0,         32'h0,         1'b1, 1};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_fn3 = '0; s_rdata = '0; s_ack = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset s_sel", 32'(s_sel), 32'd0);
        checkOutput("reset s_we", 32'(s_we), 32'd0);
        checkOutput("reset s_be", 32'(s_be), 32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].we, vecs[i].fn3, vecs[i].addr, vecs[i].wdata, vecs[i].srd,
                          vecs[i].ackWait, 20, o);
            checkTxn($sformatf("vec%0d", i), vecs[i].we, vecs[i].eLat, vecs[i].eErr, vecs[i].eRdata,
                     vecs[i].eSel, vecs[i].eBe, vecs[i].eSAddr, vecs[i].eSWdata, o);
        end

        for (int n = 0; n < 200; n++) begin
            rWe    = 1'($urandom);
            rFn3   = 3'($urandom);
            k      = $urandom_range(0, 4);
            rAddr  = (k < 4) ? (BASES[k] | ($urandom & ~MASKS[k])) : $urandom;
            rWdata = $urandom;
            rSrd   = $urandom;
            rWait  = $urandom_range(0, 3);
            refModel(rWe, rFn3, rAddr, rWdata, rSrd, eSel, eBe, eSAddr, eSWdata, eRdata, eErr);
            applyStimulus(rWe, rFn3, rAddr, rWdata, rSrd, rWait, 20, o);
            checkTxn($sformatf("rand%0d", n), rWe, eErr ? 1 : 2 + rWait, eErr, eRdata,
                     eSel, eBe, eSAddr, eSWdata, o);
        end

        // Reset while a slave is stalling: strobes drop at once and no response follows.
        applyStimulus(1'b0, 3'b010, 32'h8000_0040, 32'h0, 32'h1234_5678, 100000, 6, o);
        checkOutput("abort no response before reset", 32'(o.lat), 32'd0);
        checkOutput("abort s_sel before reset", 32'(s_sel), 32'b0001);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort async s_sel", 32'(s_sel), 32'd0);
        checkOutput("abort async rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("abort rsp_valid in reset", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        applyStimulus(1'b0, 3'b010, 32'h8000_0040, 32'h0, 32'h1234_5678, 0, 20, o);
        checkTxn("after abort", 1'b0, 2, 1'b0, 32'h1234_5678, 4'b0001, 4'hF, 32'h40, 32'h0, o);

`ifdef LSU_TIMEOUT_EN
        applyStimulus(1'b0, 3'b010, 32'h2000_0010, 32'h0, 32'h0, 100000, 400, o);
        checkTxn("timeout", 1'b0, 256, 1'b1, 32'h0, 4'b1000, 4'hF, 32'h10, 32'h0, o);
`else
        applyStimulus(1'b0, 3'b010, 32'h2000_0010, 32'h0, 32'h0, 100000, 300, o);
        checkOutput("no timeout response", 32'(o.lat), 32'd0);
        checkOutput("no timeout s_sel held", 32'(s_sel), 32'b1000);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("long wait reset s_sel", 32'(s_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        applyStimulus(1'b1, 3'b001, 32'h1000_0002, 32'h0000_BEEF, 32'h0, 0, 20, o);
        checkTxn("final store", 1'b1, 2, 1'b0, 32'h0, 4'b0010, 4'b1100, 32'h0, 32'hBEEF_BEEF, o);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
